conv_window_feeder: RTL and testbench

- Sequencer on the input side of the convolution engine.
- Walks an IMG_W x IMG_H single-channel feature map stored in synchronous-read image memory.
- For each valid 3x3 output position (stride 1, no padding) it fetches the nine pixels, presents them on win0..win8, and pulses conv_start to launch one convolution.
- It then holds the window stable until the engine's save_rstl strobe, advances to the next position, and signals done after the last one.

---
 rtl/conv_window_feeder.sv | 164 ++++++++++++++++
 tb/tb_conv_window_feeder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_feeder.sv
// Input-side sequencer for the convolution engine: walks every valid 3x3 window
// of the image memory, loads it into win0..win8 and launches one convolution per window.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | 9 reads plus one drain cycle fill the window registers (k = 0..9)
// LAUNCH | one-cycle conv_start pulse
// WAIT   | window held until the engine's save_rstl
// NEXT   | step to the following output position
// FIN    | one-cycle done pulse, busy drops
`timescale 1ns/1ps
module conv_window_feeder #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] img_raddr,
  input  logic [DATA_W-1:0] img_rdata,
  output logic [DATA_W-1:0] win0,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic [DATA_W-1:0] win4,
  output logic [DATA_W-1:0] win5,
  output logic [DATA_W-1:0] win6,
  output logic [DATA_W-1:0] win7,
  output logic [DATA_W-1:0] win8,
  output logic              conv_start,
  input  logic              save_rstl,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  localparam int AW1 = ADDR_W + 1;
  localparam logic [IDX_W-1:0] COL_MAX = IDX_W'(IMG_W - 3);
  localparam logic [IDX_W-1:0] ROW_MAX = IDX_W'(IMG_H - 3);

  logic [2:0]        state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [IDX_W-1:0]  row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];

  // Address of window pixel k at (row, col); computed one bit wider, then truncated.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [IDX_W-1:0] row,
                                                 input logic [IDX_W-1:0] col,
                                                 input logic [3:0]       k);
    logic [1:0]   dr, dc;
    logic [AW1-1:0] a;
    case (k)
      4'd0, 4'd1, 4'd2: dr = 2'd0;
      4'd3, 4'd4, 4'd5: dr = 2'd1;
      default:          dr = 2'd2;
    endcase
    case (k)
      4'd0, 4'd3, 4'd6: dc = 2'd0;
      4'd1, 4'd4, 4'd7: dc = 2'd1;
      default:          dc = 2'd2;
    endcase
    a = (AW1'(row) + AW1'(dr)) * AW1'(IMG_W) + AW1'(col) + AW1'(dc);
    return a[ADDR_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    row_d   = row_q;
    col_d   = col_q;
    raddr_d = raddr_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          k_d     = 4'd0;
          row_d   = '0;
          col_d   = '0;
          raddr_d = pix_addr('0, '0, 4'd0);
        end
      end
      S_FETCH: begin
        // read data lags the address by one cycle, so cycle k fills win[k-1]
        for (int i = 0; i < 9; i++) begin
          if (k_q == 4'(i + 1)) win_d[i] = img_rdata;
        end
        if (k_q < 4'd8) raddr_d = pix_addr(row_q, col_q, k_q + 4'd1);
        if (k_q == 4'd9) state_d = S_LAUNCH;
        else             k_d = k_q + 4'd1;
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (save_rstl) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (row_q == ROW_MAX && col_q == COL_MAX) begin
          state_d = S_FIN;
        end else begin
          if (col_q < COL_MAX) begin
            col_d = col_q + 1'b1;
          end else begin
            col_d = '0;
            if (row_q < ROW_MAX) row_d = row_q + 1'b1;
          end
          k_d     = 4'd0;
          raddr_d = pix_addr(row_d, col_d, 4'd0);
          state_d = S_FETCH;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      raddr_q <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      col_q   <= col_d;
      raddr_q <= raddr_d;
      for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
    end
  end

  assign busy       = (state_q == S_FETCH) || (state_q == S_LAUNCH) ||
                      (state_q == S_WAIT)  || (state_q == S_NEXT);
  assign done       = (state_q == S_FIN);
  assign conv_start = (state_q == S_LAUNCH);
  assign img_raddr  = raddr_q;
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign win0 = win_q[0];
  assign win1 = win_q[1];
  assign win2 = win_q[2];
  assign win3 = win_q[3];
  assign win4 = win_q[4];
  assign win5 = win_q[5];
  assign win6 = win_q[6];
  assign win7 = win_q[7];
  assign win8 = win_q[8];

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder: a 4x4 instance (a) and a 3x3 instance (b)
// share clock, reset and a simple engine model with programmable turnaround.
`timescale 1ns/1ps
module tb_conv_window_feeder;

  logic clk, rst, stray, eng_save;
  logic save_rstl;
  int   eng_delay, eng_cnt;

  logic        start_a, busy_a, done_a, conv_start_a;
  logic [9:0]  raddr_a;
  logic [15:0] rdata_a;
  logic [15:0] wa0, wa1, wa2, wa3, wa4, wa5, wa6, wa7, wa8;
  logic [4:0]  row_a, col_a;

  logic        start_b, busy_b, done_b, conv_start_b;
  logic [9:0]  raddr_b;
  logic [15:0] rdata_b;
  logic [15:0] wb0, wb1, wb2, wb3, wb4, wb5, wb6, wb7, wb8;
  logic [4:0]  row_b, col_b;

  int n_chk, n_pass;
  int launch_a, dones_a, launch_b, dones_b;

  int exp_win_a [4][9] = '{'{0, 1, 2, 4, 5, 6, 8, 9, 10},
                           '{1, 2, 3, 5, 6, 7, 9, 10, 11},
                           '{4, 5, 6, 8, 9, 10, 12, 13, 14},
                           '{5, 6, 7, 9, 10, 11, 13, 14, 15}};
  int exp_row_a [4] = '{0, 0, 1, 1};
  int exp_col_a [4] = '{0, 1, 0, 1};
  int exp_addr  [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int exp_win_b [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};

  conv_window_feeder #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .ADDR_W(10), .IDX_W(5)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .img_raddr(raddr_a), .img_rdata(rdata_a),
    .win0(wa0), .win1(wa1), .win2(wa2), .win3(wa3), .win4(wa4),
    .win5(wa5), .win6(wa6), .win7(wa7), .win8(wa8),
    .conv_start(conv_start_a), .save_rstl(save_rstl), .out_row(row_a), .out_col(col_a));

  conv_window_feeder #(.DATA_W(16), .IMG_W(3), .IMG_H(3), .ADDR_W(10), .IDX_W(5)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .img_raddr(raddr_b), .img_rdata(rdata_b),
    .win0(wb0), .win1(wb1), .win2(wb2), .win3(wb3), .win4(wb4),
    .win5(wb5), .win6(wb6), .win7(wb7), .win8(wb8),
    .conv_start(conv_start_b), .save_rstl(save_rstl), .out_row(row_b), .out_col(col_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory holds word[a] = a, one-cycle read latency
  always @(posedge clk) begin
    rdata_a <= 16'(raddr_a);
    rdata_b <= 16'(raddr_b);
  end

  // engine: save_rstl rises eng_delay cycles after conv_start
  always @(posedge clk) begin
    if (rst) begin
      eng_cnt  <= 0;
      eng_save <= 1'b0;
    end else begin
      eng_save <= 1'b0;
      if (conv_start_a || conv_start_b) begin
        eng_cnt <= eng_delay - 1;
      end else if (eng_cnt != 0) begin
        if (eng_cnt == 1) eng_save <= 1'b1;
        eng_cnt <= eng_cnt - 1;
      end
    end
  end
  assign save_rstl = eng_save | stray;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [159:0] exp_pk_a(input int n);
    logic [159:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r = {r[143:0], 16'(exp_win_a[n][k])};
    return r;
  endfunction

  function automatic logic [159:0] exp_pk_b();
    logic [159:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r = {r[143:0], 16'(exp_win_b[k])};
    return r;
  endfunction

  logic [159:0] pk_a, pk_b;
  assign pk_a = {16'h0, wa0, wa1, wa2, wa3, wa4, wa5, wa6, wa7, wa8};
  assign pk_b = {16'h0, wb0, wb1, wb2, wb3, wb4, wb5, wb6, wb7, wb8};

  always @(negedge clk) begin
    if (conv_start_a) begin
      if (launch_a < 4) begin
        chk($sformatf("win_a_%0d", launch_a), pk_a, exp_pk_a(launch_a));
        chk($sformatf("row_a_%0d", launch_a), 160'(row_a), 160'(exp_row_a[launch_a]));
        chk($sformatf("col_a_%0d", launch_a), 160'(col_a), 160'(exp_col_a[launch_a]));
      end else begin
        chk("extra_launch_a", 160'(launch_a), 160'd3);
      end
      launch_a++;
    end
    if (done_a) begin
      dones_a++;
      chk("busy_a_at_done", 160'(busy_a), 160'd0);
    end
    if (conv_start_b) begin
      chk("win_b", pk_b, exp_pk_b());
      chk("rowcol_b", 160'({row_b, col_b}), 160'd0);
      launch_b++;
    end
    if (done_b) dones_b++;
  end

  task automatic wait_launch_a(input int target);
    int n = 0;
    while (launch_a < target && n < 2000) begin @(negedge clk); n++; end
    chk("launch_a_wait", 160'(launch_a >= target), 160'd1);
  endtask

  task automatic wait_done_a(input int target);
    int n = 0;
    while (dones_a < target && n < 3000) begin @(negedge clk); n++; end
    chk("done_a_wait", 160'(dones_a >= target), 160'd1);
  endtask

  task automatic wait_done_b(input int target);
    int n = 0;
    while (dones_b < target && n < 3000) begin @(negedge clk); n++; end
    chk("done_b_wait", 160'(dones_b >= target), 160'd1);
  endtask

  task automatic pulse_start_a();
    launch_a = 0;
    dones_a  = 0;
    start_a  = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
  endtask

  task automatic check_zero_a(input string tag);
    chk({tag, "_busy"},  160'(busy_a), 160'd0);
    chk({tag, "_done"},  160'(done_a), 160'd0);
    chk({tag, "_cs"},    160'(conv_start_a), 160'd0);
    chk({tag, "_raddr"}, 160'(raddr_a), 160'd0);
    chk({tag, "_win"},   pk_a, 160'd0);
    chk({tag, "_row"},   160'(row_a), 160'd0);
    chk({tag, "_col"},   160'(col_a), 160'd0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    launch_a = 0; dones_a = 0; launch_b = 0; dones_b = 0;
    rst = 1'b1; stray = 1'b0; start_a = 1'b0; start_b = 1'b0; eng_delay = 5;
    repeat (3) @(negedge clk);
    check_zero_a("reset");
    chk("reset_busy_b", 160'(busy_b), 160'd0);
    rst = 1'b0;
    @(negedge clk);

    // pass 1: cycle-exact fetch, start ignored during FETCH and WAIT
    pulse_start_a();
    chk("busy_after_start", 160'(busy_a), 160'd1);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("raddr_%0d", i), 160'(raddr_a), 160'(exp_addr[i]));
      if (i == 2) start_a = 1'b1;
      if (i == 3) start_a = 1'b0;
      @(negedge clk);
    end
    chk("cs_drain", 160'(conv_start_a), 160'd0);
    @(negedge clk);
    chk("cs_launch", 160'(conv_start_a), 160'd1);
    @(negedge clk);
    chk("cs_after", 160'(conv_start_a), 160'd0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(1);
    repeat (5) @(negedge clk);
    chk("p1_launches", 160'(launch_a), 160'd4);
    chk("p1_dones", 160'(dones_a), 160'd1);
    chk("p1_busy_idle", 160'(busy_a), 160'd0);
    chk("p1_final_rc", 160'({row_a, col_a}), 160'({5'd1, 5'd1}));

    // pass 2: slow engine, window must stay static
    eng_delay = 55;
    pulse_start_a();
    wait_launch_a(1);
    for (int j = 1; j <= 50; j++) begin
      @(negedge clk);
      if (j % 10 == 0) begin
        chk($sformatf("hold_win_%0d", j), pk_a, exp_pk_a(0));
        chk($sformatf("hold_rc_%0d", j), 160'({row_a, col_a}), 160'd0);
        chk($sformatf("hold_raddr_%0d", j), 160'(raddr_a), 160'd10);
        chk($sformatf("hold_launch_%0d", j), 160'(launch_a), 160'd1);
        chk($sformatf("hold_busy_%0d", j), 160'(busy_a), 160'd1);
      end
    end
    wait_done_a(1);
    repeat (3) @(negedge clk);
    chk("p2_launches", 160'(launch_a), 160'd4);

    // pass 3: reset while waiting at (0,1)
    pulse_start_a();
    wait_launch_a(2);
    repeat (3) @(negedge clk);
    chk("pre_rst_col", 160'(col_a), 160'd1);
    rst = 1'b1;
    @(negedge clk);
    check_zero_a("midrst");
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("abandon_no_done", 160'(dones_a), 160'd0);
    chk("abandon_idle", 160'(busy_a), 160'd0);
    eng_delay = 5;
    pulse_start_a();
    wait_done_a(1);
    repeat (3) @(negedge clk);
    chk("p4_launches", 160'(launch_a), 160'd4);
    chk("p4_dones", 160'(dones_a), 160'd1);

    // 3x3 image: single window, stray save_rstl in FETCH and LAUNCH
    launch_b = 0; dones_b = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (2) @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (7) @(negedge clk);
    chk("b_cs_launch", 160'(conv_start_b), 160'd1);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    chk("b_stray_no_done", 160'(dones_b), 160'd0);
    chk("b_stray_busy", 160'(busy_b), 160'd1);
    wait_done_b(1);
    repeat (5) @(negedge clk);
    chk("b_launches", 160'(launch_b), 160'd1);
    chk("b_dones", 160'(dones_b), 160'd1);
    chk("b_idle", 160'(busy_b), 160'd0);
    chk("b_raddr_last", 160'(raddr_b), 160'd8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
